fetch_pc_ctrl: RTL and testbench

Parametrised program-counter and fetch-hazard controller for the 5-stage pipeline; generalisation of the current PC register. Owns the PC, generates its own sequential increment, and handles branch-resolution stalls, J/JAL/JR redirects and load-use stalls through an explicit state machine. Adds a configurable branch-wait depth, a circular return-address stack (RAS), and an rt=$0 load-use exemption. Sits in IF, driving the instruction-memory address, and takes decoded signals back from ID.

---
 rtl/fetch_pc_ctrl_if.sv | 74 +++++++
 rtl/fetch_pc_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_ctrl_if
//
// Bundles every non-clock signal between the IF-stage program-counter/hazard
// controller (fetch_pc_ctrl) and the rest of the pipeline.
//
// Signals:
//   Instruction   32          instruction currently held in IF/ID
//   LookAhead     32          instruction immediately following Instruction
//   BranchValid   1           ID has resolved the pending branch this cycle
//   BranchTaken   1           resolved direction, meaningful with BranchValid
//   BranchOffset  16          signed word offset, meaningful when taken
//   JumpRegister  1           JR sits in ID this cycle
//   RegTarget     ADDR_WIDTH  JR target register value
//   PCResult      ADDR_WIDTH  registered fetch address
//   Stall         1           registered; IF/ID must hold while 1
//   WriteRA       1           registered one-cycle pulse: write link to $31
//   RASTop        ADDR_WIDTH  top return-address-stack entry
//   RASEmpty      1           return-address stack holds no entries
//   RASHit        1           RAS top matches RegTarget
//
// Modports:
//   master  the controller (drives the fetch address and hazard outputs)
//   slave   the pipeline side (drives decoded instruction / resolution info)
// -----------------------------------------------------------------------------
interface fetch_pc_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [31:0]           Instruction;
    logic [31:0]           LookAhead;
    logic                  BranchValid;
    logic                  BranchTaken;
    logic [15:0]           BranchOffset;
    logic                  JumpRegister;
    logic [ADDR_WIDTH-1:0] RegTarget;
    logic [ADDR_WIDTH-1:0] PCResult;
    logic                  Stall;
    logic                  WriteRA;
    logic [ADDR_WIDTH-1:0] RASTop;
    logic                  RASEmpty;
    logic                  RASHit;

    modport master (
        input  Instruction,
        input  LookAhead,
        input  BranchValid,
        input  BranchTaken,
        input  BranchOffset,
        input  JumpRegister,
        input  RegTarget,
        output PCResult,
        output Stall,
        output WriteRA,
        output RASTop,
        output RASEmpty,
        output RASHit
    );

    modport slave (
        output Instruction,
        output LookAhead,
        output BranchValid,
        output BranchTaken,
        output BranchOffset,
        output JumpRegister,
        output RegTarget,
        input  PCResult,
        input  Stall,
        input  WriteRA,
        input  RASTop,
        input  RASEmpty,
        input  RASHit
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_pc_ctrl
//
// Program-counter and fetch-hazard controller for the IF stage of the 5-stage
// pipeline. Owns the PC and its sequential increment, and resolves the three
// fetch hazards through a small state machine:
//   RUN       normal fetch; decodes the instruction in IF/ID
//   BR_WAIT   branch seen; hold the PC until ID resolves it
//   JAL_WAIT  JAL seen; link write issued, jump on the following cycle
//   LD_STALL  load-use hazard; exactly one bubble
// A circular return-address stack (RAS) records the PC of every JAL and is
// popped by JR so that the pipeline can compare predicted and real targets.
//
// Parameters:
//   ADDR_WIDTH   width of PC and all address ports
//   INCR         sequential increment (1 = word, 4 = byte addressing)
//   RESET_ADDR   PC value after reset
//   BRANCH_WAIT  cycles held after branch detection before a resolution is
//                accepted (>= 1)
//   RAS_DEPTH    return-address-stack entries (power of 2, >= 2)
//
// Ports:
//   Clk    clock, all state updates on the rising edge
//   Reset  synchronous, active-high; overrides every other input
//   bus    fetch_pc_ctrl_if.master, see the interface for signal meanings
// -----------------------------------------------------------------------------
module fetch_pc_ctrl #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           INCR        = 1,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
    parameter int unsigned           BRANCH_WAIT = 2,
    parameter int unsigned           RAS_DEPTH   = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    fetch_pc_ctrl_if.master  bus
);

    // Wait counter only ever holds BRANCH_WAIT-1 down to 0.
    localparam int CNT_W = (BRANCH_WAIT > 1) ? $clog2(BRANCH_WAIT) : 1;
    localparam int PTR_W = $clog2(RAS_DEPTH);

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_LW     = 6'b100011;

    typedef enum logic [1:0] {
        RUN,
        BR_WAIT,
        JAL_WAIT,
        LD_STALL
    } state_t;

    state_t                state_q, state_nxt;
    logic [ADDR_WIDTH-1:0] pc_q, pc_nxt;
    logic                  stall_q, stall_nxt;
    logic                  write_ra_q, write_ra_nxt;
    logic [CNT_W-1:0]      cnt_q, cnt_nxt;

    // ---------------------------------------------------------------------
    // Instruction decode
    // ---------------------------------------------------------------------
    logic [5:0] opcode;
    logic [4:0] rt;
    logic       is_branch;
    logic       is_j;
    logic       is_jal;
    logic       load_use;

    assign opcode = bus.Instruction[31:26];
    assign rt     = bus.Instruction[20:16];

    // BLEZ/BGTZ only count as branches in their canonical rt=$0 encoding.
    assign is_branch = (opcode == OP_REGIMM) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                       (((opcode == OP_BLEZ) || (opcode == OP_BGTZ)) && (rt == 5'd0));
    assign is_j   = (opcode == OP_J);
    assign is_jal = (opcode == OP_JAL);

    // $0 is hard-wired, so a load into it can never create a real dependency.
    assign load_use = (opcode == OP_LW) && (rt != 5'd0) &&
                      ((rt == bus.LookAhead[25:21]) || (rt == bus.LookAhead[20:16]));

    // Only the rs/rt fields of LookAhead matter; the rest is deliberately ignored.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.Instruction, bus.LookAhead[31:26], bus.LookAhead[15:0]};

    // ---------------------------------------------------------------------
    // Address arithmetic (all modulo 2^ADDR_WIDTH)
    // ---------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] pc_incr;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic [ADDR_WIDTH-1:0] branch_target;

    assign pc_incr       = pc_q + ADDR_WIDTH'(INCR);
    // Zero-extends the 26-bit index, or truncates it on narrow address buses.
    assign jump_target   = ADDR_WIDTH'(bus.Instruction[25:0]);
    assign branch_target = pc_q + ADDR_WIDTH'($signed(bus.BranchOffset));

    // ---------------------------------------------------------------------
    // Return-address stack
    // ---------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]      ras_ptr;    // index of the current top entry
    logic [PTR_W:0]        ras_count;  // number of valid entries, saturating
    logic                  ras_push;
    logic                  ras_pop;
    logic                  ras_empty;
    logic                  ras_full;

    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == (PTR_W+1)'(RAS_DEPTH));

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (Reset) begin
            ras_ptr   <= '0;
            ras_count <= '0;
        end else if (ras_push) begin
            // A full stack wraps onto its oldest entry; the count stays saturated.
            ras_ptr <= ras_ptr + PTR_W'(1);
            if (!ras_full) begin
                ras_count <= ras_count + (PTR_W+1)'(1);
            end
        end else if (ras_pop) begin
            ras_ptr   <= ras_ptr - PTR_W'(1);
            ras_count <= ras_count - (PTR_W+1)'(1);
        end
    end

    // NOTE: the entry array has no reset; a zero count already marks every entry
    // invalid, so clearing the storage itself would only cost reset fan-out.
    always_ff @(posedge Clk) begin
        if (!Reset && ras_push) begin
            ras_mem[ras_ptr + PTR_W'(1)] <= pc_q;
        end
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_ADDR;
            stall_q    <= 1'b0;
            write_ra_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_nxt;
            pc_q       <= pc_nxt;
            stall_q    <= stall_nxt;
            write_ra_q <= write_ra_nxt;
            cnt_q      <= cnt_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and output logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves one unassigned and infers a latch.
        state_nxt    = state_q;
        pc_nxt       = pc_q;
        stall_nxt    = stall_q;
        write_ra_nxt = 1'b0;
        cnt_nxt      = cnt_q;
        ras_push     = 1'b0;
        ras_pop      = 1'b0;

        unique case (state_q)
            RUN: begin
                stall_nxt = 1'b0;
                if (bus.JumpRegister) begin
                    pc_nxt  = bus.RegTarget;
                    ras_pop = !ras_empty;
                end else if (is_branch) begin
                    stall_nxt = 1'b1;
                    cnt_nxt   = CNT_W'(BRANCH_WAIT - 1);
                    state_nxt = BR_WAIT;
                end else if (is_j) begin
                    pc_nxt = jump_target;
                end else if (is_jal) begin
                    // Link value pushed is the PC of the JAL itself.
                    write_ra_nxt = 1'b1;
                    stall_nxt    = 1'b1;
                    ras_push     = 1'b1;
                    state_nxt    = JAL_WAIT;
                end else if (load_use) begin
                    stall_nxt = 1'b1;
                    state_nxt = LD_STALL;
                end else begin
                    pc_nxt = pc_incr;
                end
            end

            BR_WAIT: begin
                // Resolutions arriving before the wait window has drained are
                // stale and ignored; there is deliberately no timeout.
                stall_nxt = 1'b1;
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end else if (bus.BranchValid) begin
                    // Not taken keeps the held PC, which is already the
                    // fall-through fetch address.
                    if (bus.BranchTaken) begin
                        pc_nxt = branch_target;
                    end
                    stall_nxt = 1'b0;
                    state_nxt = RUN;
                end
            end

            JAL_WAIT: begin
                // IF/ID is still holding the JAL, so its target is on Instruction.
                pc_nxt    = jump_target;
                stall_nxt = 1'b0;
                state_nxt = RUN;
            end

            LD_STALL: begin
                pc_nxt    = pc_incr;
                stall_nxt = 1'b0;
                state_nxt = RUN;
            end

            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.PCResult = pc_q;
    assign bus.Stall    = stall_q;
    assign bus.WriteRA  = write_ra_q;
    assign bus.RASTop   = ras_mem[ras_ptr];
    assign bus.RASEmpty = ras_empty;
    assign bus.RASHit   = !ras_empty && (ras_mem[ras_ptr] == bus.RegTarget);

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_ctrl
//
// Self-checking bench for fetch_pc_ctrl (ADDR_WIDTH=16, INCR=1, RESET_ADDR=0,
// BRANCH_WAIT=2, RAS_DEPTH=4). Every cycle is compared against a behavioural
// model (pending-action flags plus a queue for the return-address stack);
// a vector table and hand-written sequences add fixed expected values on top.
// -----------------------------------------------------------------------------
module tb_fetch_pc_ctrl;

    localparam int            AW     = 16;
    localparam int            INCR_V = 1;
    localparam int            BW     = 2;
    localparam int            DEPTH  = 4;
    localparam logic [AW-1:0] RST_PC = 16'h0000;
    localparam logic [31:0]   NOP    = 32'h0000_0000;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    fetch_pc_ctrl_if #(.ADDR_WIDTH(AW)) bus();

    fetch_pc_ctrl #(
        .ADDR_WIDTH (AW),
        .INCR       (INCR_V),
        .RESET_ADDR (RST_PC),
        .BRANCH_WAIT(BW),
        .RAS_DEPTH  (DEPTH)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    logic [AW-1:0] m_pc;
    logic          m_stall;
    logic          m_wra;
    int            m_br_hold;     // -1: no branch outstanding; else cycles left to ignore
    bit            m_jal_pend;
    bit            m_ld_pend;
    logic [AW-1:0] m_ras[$];      // back of queue is the top of stack
    bit            model_valid = 1'b0;

    function automatic void model_step(input logic rst, input logic [31:0] ins,
                                       input logic [31:0] look, input logic bv,
                                       input logic bt, input logic [15:0] off,
                                       input logic jr, input logic [AW-1:0] tgt);
        logic [5:0] op;
        logic [4:0] r;
        int         t;
        op    = ins[31:26];
        r     = ins[20:16];
        m_wra = 1'b0;
        if (rst) begin
            m_pc       = RST_PC;
            m_stall    = 1'b0;
            m_br_hold  = -1;
            m_jal_pend = 1'b0;
            m_ld_pend  = 1'b0;
            m_ras.delete();
        end else if (m_br_hold > 0) begin
            m_br_hold = m_br_hold - 1;
        end else if (m_br_hold == 0) begin
            if (bv) begin
                if (bt) begin
                    t    = int'(m_pc) + int'($signed(off));
                    m_pc = AW'(t);
                end
                m_br_hold = -1;
                m_stall   = 1'b0;
            end
        end else if (m_jal_pend) begin
            m_pc       = ins[15:0];
            m_jal_pend = 1'b0;
            m_stall    = 1'b0;
        end else if (m_ld_pend) begin
            m_pc      = AW'(int'(m_pc) + INCR_V);
            m_ld_pend = 1'b0;
            m_stall   = 1'b0;
        end else begin
            m_stall = 1'b0;
            if (jr) begin
                m_pc = tgt;
                if (m_ras.size() != 0) void'(m_ras.pop_back());
            end else if ((op inside {6'd1, 6'd4, 6'd5}) || ((op inside {6'd6, 6'd7}) && r == 5'd0)) begin
                m_stall   = 1'b1;
                m_br_hold = BW - 1;
            end else if (op == 6'd2) begin
                m_pc = ins[15:0];
            end else if (op == 6'd3) begin
                m_wra      = 1'b1;
                m_stall    = 1'b1;
                m_jal_pend = 1'b1;
                m_ras.push_back(m_pc);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (op == 6'b100011 && r != 5'd0 && (r == look[25:21] || r == look[20:16])) begin
                m_stall   = 1'b1;
                m_ld_pend = 1'b1;
            end else begin
                m_pc = AW'(int'(m_pc) + INCR_V);
            end
        end
    endfunction

    // -------------------------------------------------------------------------
    // Instruction encoders
    // -------------------------------------------------------------------------
    function automatic logic [31:0] i_br(input int op, input int rs, input int rt);
        return {6'(op), 5'(rs), 5'(rt), 16'h0010};
    endfunction
    function automatic logic [31:0] i_j(input int tgt);
        return {6'b000010, 26'(tgt)};
    endfunction
    function automatic logic [31:0] i_jal(input int tgt);
        return {6'b000011, 26'(tgt)};
    endfunction
    function automatic logic [31:0] i_lw(input int rt, input int base);
        return {6'b100011, 5'(base), 5'(rt), 16'h0004};
    endfunction
    function automatic logic [31:0] i_add(input int rd, input int rs, input int rt);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'b100000};
    endfunction

    // -------------------------------------------------------------------------
    // Checking and stimulus helpers
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] ins, input logic [31:0] look, input logic bv,
                          input logic bt, input logic [15:0] off, input logic jr,
                          input logic [AW-1:0] tgt);
        bus.Instruction  = ins;
        bus.LookAhead    = look;
        bus.BranchValid  = bv;
        bus.BranchTaken  = bt;
        bus.BranchOffset = off;
        bus.JumpRegister = jr;
        bus.RegTarget    = tgt;
    endtask

    // One clock: combinational check before the edge, registered checks after.
    task automatic cycle();
        logic exp_hit;
        #1;
        if (model_valid) begin
            exp_hit = (m_ras.size() != 0) && (m_ras[$] == bus.RegTarget);
            check("model_RASHit", 32'(bus.RASHit), 32'(exp_hit));
        end
        model_step(Reset, bus.Instruction, bus.LookAhead, bus.BranchValid, bus.BranchTaken,
                   bus.BranchOffset, bus.JumpRegister, bus.RegTarget);
        model_valid = 1'b1;
        @(posedge Clk);
        #1;
        check("model_PCResult", 32'(bus.PCResult), 32'(m_pc));
        check("model_Stall",    32'(bus.Stall),    32'(m_stall));
        check("model_WriteRA",  32'(bus.WriteRA),  32'(m_wra));
        check("model_RASEmpty", 32'(bus.RASEmpty), 32'(m_ras.size() == 0));
        if (m_ras.size() != 0) check("model_RASTop", 32'(bus.RASTop), 32'(m_ras[$]));
    endtask

    // Shorthand for a plain cycle with only Instruction/JR varying.
    task automatic run(input logic [31:0] ins, input logic jr, input logic [AW-1:0] tgt);
        set_in(ins, NOP, 1'b0, 1'b0, 16'h0, jr, tgt);
        cycle();
    endtask

    typedef struct {
        logic [31:0]   ins;
        logic [31:0]   look;
        logic          bv;
        logic          bt;
        logic [15:0]   off;
        logic          jr;
        logic [AW-1:0] tgt;
        logic [AW-1:0] e_pc;
        logic          e_stall;
        logic          e_wra;
        logic          e_empty;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] look, input logic bv,
                                input logic bt, input logic [15:0] off, input logic jr,
                                input logic [AW-1:0] tgt, input logic [AW-1:0] e_pc,
                                input logic e_stall, input logic e_wra, input logic e_empty);
        vec_t v;
        v.ins = ins; v.look = look; v.bv = bv; v.bt = bt; v.off = off; v.jr = jr; v.tgt = tgt;
        v.e_pc = e_pc; v.e_stall = e_stall; v.e_wra = e_wra; v.e_empty = e_empty;
        return v;
    endfunction

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    initial begin
        vec_t          tbl[$];
        logic [31:0]   r_ins, r_look;
        logic [AW-1:0] r_tgt;
        int            sel;

        // Reset state
        Reset = 1'b1;
        run(NOP, 1'b0, '0);
        check("reset_pc",    32'(bus.PCResult), 32'(RST_PC));
        check("reset_stall", 32'(bus.Stall),    32'd0);
        check("reset_wra",   32'(bus.WriteRA),  32'd0);
        check("reset_empty", 32'(bus.RASEmpty), 32'd1);
        Reset = 1'b0;

        //             ins               look            bv    bt    off      jr    tgt      pc       st    wra   empty
        tbl.push_back(mk(NOP,            NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd1,   1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(NOP,            NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd2,   1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(NOP,            NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd3,   1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(i_j(10),        NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd10,  1'b0, 1'b0, 1'b1));
        // BEQ at 10, stale resolution ignored, then taken by -4
        tbl.push_back(mk(i_br(4,1,2),    NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd10,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(NOP,            NOP,            1'b1, 1'b1, 16'd100, 1'b0, 16'h0,   16'd10,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(NOP,            NOP,            1'b1, 1'b1, 16'hFFFC,1'b0, 16'h0,   16'd6,   1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(NOP,            NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd7,   1'b0, 1'b0, 1'b1));
        // BEQ at 10, one idle wait cycle, then not taken
        tbl.push_back(mk(i_j(10),        NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd10,  1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(i_br(4,1,2),    NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd10,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(NOP,            NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd10,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(NOP,            NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd10,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(NOP,            NOP,            1'b1, 1'b0, 16'h7,   1'b0, 16'h0,   16'd10,  1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(NOP,            NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd11,  1'b0, 1'b0, 1'b1));
        // JAL 0x40 at 8, then JR back through the RAS
        tbl.push_back(mk(i_j(8),         NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd8,   1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(i_jal(32'h40),  NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd8,   1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(i_jal(32'h40),  NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'h40,  1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(NOP,            NOP,            1'b0, 1'b0, 16'h0,   1'b1, 16'd8,   16'd8,   1'b0, 1'b0, 1'b1));
        // Load-use: dependent ADD stalls once; $0 and independent LW do not
        tbl.push_back(mk(i_lw(5,2),      i_add(7,5,3),   1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd8,   1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(i_lw(5,2),      i_add(7,5,3),   1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd9,   1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(i_lw(0,2),      i_add(7,0,0),   1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd10,  1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(i_lw(5,2),      i_lw(6,2),      1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd11,  1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(i_lw(5,2),      i_add(7,3,5),   1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd11,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(NOP,            NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd12,  1'b0, 1'b0, 1'b1));
        // BGTZ with rt!=0 is not a branch; BLEZ rt=0 is, taken by +5
        tbl.push_back(mk(i_br(7,1,3),    NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd13,  1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(i_br(6,1,0),    NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd13,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(NOP,            NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'd13,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(NOP,            NOP,            1'b1, 1'b1, 16'd5,   1'b0, 16'h0,   16'd18,  1'b0, 1'b0, 1'b1));
        // JR with empty RAS; J truncation and PC wrap
        tbl.push_back(mk(NOP,            NOP,            1'b0, 1'b0, 16'h0,   1'b1, 16'h20,  16'h20,  1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(i_j(32'h2FFFF), NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'hFFFF,1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(NOP,            NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'h0,   1'b0, 1'b0, 1'b1));
        // JR beats a branch in RUN; JR ignored inside BR_WAIT; REGIMM taken by -1
        tbl.push_back(mk(i_br(4,1,2),    NOP,            1'b0, 1'b0, 16'h0,   1'b1, 16'h30,  16'h30,  1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(i_br(1,1,1),    NOP,            1'b0, 1'b0, 16'h0,   1'b0, 16'h0,   16'h30,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(NOP,            NOP,            1'b0, 1'b0, 16'h0,   1'b1, 16'h99,  16'h30,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(NOP,            NOP,            1'b1, 1'b1, 16'hFFFF,1'b1, 16'h99,  16'h2F,  1'b0, 1'b0, 1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].ins, tbl[i].look, tbl[i].bv, tbl[i].bt, tbl[i].off, tbl[i].jr, tbl[i].tgt);
            cycle();
            check($sformatf("vec%0d_pc", i),    32'(bus.PCResult), 32'(tbl[i].e_pc));
            check($sformatf("vec%0d_stall", i), 32'(bus.Stall),    32'(tbl[i].e_stall));
            check($sformatf("vec%0d_wra", i),   32'(bus.WriteRA),  32'(tbl[i].e_wra));
            check($sformatf("vec%0d_empty", i), 32'(bus.RASEmpty), 32'(tbl[i].e_empty));
        end

        // Reset in the middle of a branch wait
        run(i_br(4,1,2), 1'b0, '0);
        check("midbr_stall", 32'(bus.Stall), 32'd1);
        Reset = 1'b1;
        set_in(NOP, NOP, 1'b1, 1'b1, 16'd7, 1'b0, '0);
        cycle();
        Reset = 1'b0;
        check("midbr_reset_pc",    32'(bus.PCResult), 32'd0);
        check("midbr_reset_stall", 32'(bus.Stall),    32'd0);
        run(NOP, 1'b0, '0);
        check("midbr_run_pc", 32'(bus.PCResult), 32'd1);

        // Branch left unresolved for 5 extra cycles, then taken by +3
        run(i_br(5,1,2), 1'b0, '0);
        run(NOP, 1'b0, '0);
        for (int k = 0; k < 5; k++) begin
            run(NOP, 1'b0, '0);
            check("longwait_stall", 32'(bus.Stall),    32'd1);
            check("longwait_pc",    32'(bus.PCResult), 32'd1);
        end
        set_in(NOP, NOP, 1'b1, 1'b1, 16'd3, 1'b0, '0);
        cycle();
        check("longwait_res_pc",    32'(bus.PCResult), 32'd4);
        check("longwait_res_stall", 32'(bus.Stall),    32'd0);

        // Five JALs into a 4-deep RAS, then LIFO pops
        for (int k = 0; k < 5; k++) begin
            run(i_j(16 * (k + 1)), 1'b0, '0);
            run(i_jal(32'h200), 1'b0, '0);
            check("ras_push_top", 32'(bus.RASTop),  32'(16 * (k + 1)));
            check("ras_push_wra", 32'(bus.WriteRA), 32'd1);
            run(i_jal(32'h200), 1'b0, '0);
            check("ras_jal_pc",   32'(bus.PCResult), 32'h200);
        end
        for (int k = 0; k < 4; k++) begin
            check("ras_lifo_top", 32'(bus.RASTop), 32'(80 - 16 * k));
            set_in(NOP, NOP, 1'b0, 1'b0, 16'h0, 1'b1, AW'(80 - 16 * k));
            #1;
            check("ras_lifo_hit", 32'(bus.RASHit), 32'd1);
            cycle();
            check("ras_lifo_pc",    32'(bus.PCResult), 32'(80 - 16 * k));
            check("ras_lifo_empty", 32'(bus.RASEmpty), 32'(k == 3));
        end
        run(NOP, 1'b1, 16'h123);
        check("ras_underflow_pc",    32'(bus.PCResult), 32'h123);
        check("ras_underflow_empty", 32'(bus.RASEmpty), 32'd1);

        // Randomised traffic against the model
        for (int c = 0; c < 1500; c++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       r_ins = i_br(int'($urandom_range(4, 7)), 1, int'($urandom_range(0, 1)));
                1:       r_ins = i_br(1, 2, int'($urandom_range(0, 31)));
                2:       r_ins = i_j(int'($urandom));
                3:       r_ins = i_jal(int'($urandom));
                4, 5:    r_ins = i_lw(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                default: r_ins = i_add(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                                       int'($urandom_range(0, 3)));
            endcase
            r_look = ($urandom_range(0, 1) == 0)
                   ? i_add(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)))
                   : i_lw(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            r_tgt  = (m_ras.size() != 0 && $urandom_range(0, 1) == 0) ? m_ras[$] : AW'($urandom);
            Reset  = ($urandom_range(0, 99) == 0);
            set_in(r_ins, r_look, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   16'($urandom), ($urandom_range(0, 7) == 0), r_tgt);
            cycle();
        end
        Reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
